// File: rtl/nios_sd_loader_pkg.sv
// Shared definitions for the SD-loader memory writer: default geometry,
// FSM state encoding and byte-lane helpers.
package nios_sd_loader_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DEPTH  = 24576;
  localparam int DEF_LEN_W  = 17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Next free byte lane for a contiguous low-aligned byteenable mask.
  function automatic logic [1:0] lane_of(input logic [3:0] be);
    case (be)
      4'b0001: return 2'd1;
      4'b0011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/nios_sd_loader_mem_writer_if.sv
// Byte-stream sink plus Avalon-MM write master bundle of the SD-loader writer.
interface nios_sd_loader_mem_writer_if
  import nios_sd_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic              m_write;
  logic [31:0]       m_writedata;
  logic              m_waitrequest;

  modport master (
    input  s_data, s_valid, m_waitrequest,
    output s_ready, m_address, m_byteenable, m_write, m_writedata
  );

  modport slave (
    output s_data, s_valid, m_waitrequest,
    input  s_ready, m_address, m_byteenable, m_write, m_writedata
  );

endinterface

// File: rtl/nios_sd_loader_byte_packer.sv
// Packs stream bytes little-endian into a 32-bit word and tracks filled lanes
// as a byteenable mask; unfilled lanes always read as zero.
module nios_sd_loader_byte_packer
  import nios_sd_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic [3:0]  o_be
);

  logic [31:0] r_word;
  logic [3:0]  r_be;
  logic [1:0]  w_lane;

  assign w_lane = lane_of(r_be);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_be   <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_be   <= '0;
    end else if (i_push) begin
      r_word[{w_lane, 3'b000} +: 8] <= i_data;
      r_be                          <= {r_be[2:0], 1'b1};
    end
  end

  assign o_word = r_word;
  assign o_be   = r_be;

endmodule

// File: rtl/nios_sd_loader_mem_writer.sv
// Streams SD sector bytes into on-chip memory through an Avalon-MM write
// master, one 32-bit word per write, with a start-time range check.
module nios_sd_loader_mem_writer
  import nios_sd_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  byte_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest
);

  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 2;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_s_ready;
  logic              r_m_write;

  logic              w_push;
  logic              w_accept;
  logic              w_word_full;
  logic              w_last_byte;
  logic              w_range_err;
  logic [LEN_W:0]    w_words;
  logic [SUM_W-1:0]  w_end;
  logic [31:0]       w_word;
  logic [3:0]        w_be;

  assign w_push      = (r_state == ST_FILL) && s_valid && r_s_ready;
  assign w_accept    = (r_state == ST_WRITE) && r_m_write && !m_waitrequest;
  assign w_word_full = w_be[2];
  assign w_last_byte = (r_remaining == LEN_W'(1));

  // Range check works in a widened domain so base + words cannot overflow.
  assign w_words     = ({1'b0, byte_count} + (LEN_W+1)'(3)) >> 2;
  assign w_end       = SUM_W'(base_addr) + SUM_W'(w_words);
  assign w_range_err = (w_end > SUM_W'(DEPTH));

  nios_sd_loader_byte_packer u_packer (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_clear (w_accept),
    .i_push  (w_push),
    .i_data  (s_data),
    .o_word  (w_word),
    .o_be    (w_be)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_s_ready   <= 1'b0;
      r_m_write   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (byte_count == '0) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else if (w_range_err) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state     <= ST_FILL;
              r_addr      <= base_addr;
              r_remaining <= byte_count;
              r_busy      <= 1'b1;
              r_s_ready   <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (w_push) begin
            r_remaining <= r_remaining - LEN_W'(1);
            // Drop ready on the completing byte so no fifth byte slips in.
            if (w_word_full || w_last_byte) begin
              r_state   <= ST_WRITE;
              r_s_ready <= 1'b0;
              r_m_write <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (w_accept) begin
            r_m_write <= 1'b0;
            r_addr    <= r_addr + ADDR_W'(1);
            if (r_remaining != '0) begin
              r_state   <= ST_FILL;
              r_s_ready <= 1'b1;
            end else begin
              r_state <= ST_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign s_ready      = r_s_ready;
  assign m_address    = r_addr;
  assign m_write      = r_m_write;
  assign m_writedata  = w_word;
  assign m_byteenable = w_be;

endmodule

// File: tb/tb_nios_sd_loader_mem_writer.sv
// Directed and randomized bench for nios_sd_loader_mem_writer with a
// word-list reference model derived from base/count/byte values.
module tb_nios_sd_loader_mem_writer;
  import nios_sd_loader_pkg::*;

  localparam int ADDR_W = DEF_ADDR_W;
  localparam int DEPTH  = DEF_DEPTH;
  localparam int LEN_W  = DEF_LEN_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  byte_count;
  logic              busy, done, error;

  nios_sd_loader_mem_writer_if #(.ADDR_W(ADDR_W)) bus ();

  nios_sd_loader_mem_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .base_addr     (base_addr),
    .byte_count    (byte_count),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .s_data        (bus.s_data),
    .s_valid       (bus.s_valid),
    .s_ready       (bus.s_ready),
    .m_address     (bus.m_address),
    .m_byteenable  (bus.m_byteenable),
    .m_write       (bus.m_write),
    .m_writedata   (bus.m_writedata),
    .m_waitrequest (bus.m_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  src [0:63];
  wr_t         exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected writes: one per started group of four bytes, little-endian.
  task automatic build_model(input int base, input int count);
    exp_q.delete();
    for (int w = 0; w * 4 < count; w++) begin
      wr_t e;
      int  n;
      n = count - 4 * w;
      if (n > 4) n = 4;
      e.addr = base + w;
      e.data = '0;
      for (int k = 0; k < n; k++) e.data = e.data | (32'(src[4*w+k]) << (8 * k));
      e.be = 4'((1 << n) - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_xfer(input string tag, input int base, input int count,
                          input int vmode, input int wmode, input bit poke);
    int words      = (count + 3) / 4;
    bit exp_err    = (count != 0) && (base + words > DEPTH);
    bit quick      = (count == 0) || exp_err;
    int idx        = 0;
    int widx       = 0;
    int cyc        = 0;
    int done_cnt   = 0;
    int stall_seen = 0;
    int first_hold = 0;
    bit first_done = 0;
    bit prev_stall = 0;
    bit finished   = 0;
    logic [ADDR_W-1:0] pa;
    logic [31:0]       pd;
    logic [3:0]        pb;

    if (quick) exp_q.delete();
    else build_model(base, count);

    @(posedge clk); #1;
    start = 1'b1;
    base_addr = ADDR_W'(base);
    byte_count = LEN_W'(count);
    bus.s_valid = 1'b0;
    bus.m_waitrequest = (wmode == 1);
    @(posedge clk); #1;
    start = 1'b0;

    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        check({tag, "/hold_write"}, bus.m_write, 1);
        check({tag, "/hold_addr"}, bus.m_address, pa);
        check({tag, "/hold_data"}, bus.m_writedata, pd);
        check({tag, "/hold_be"}, bus.m_byteenable, pb);
        check({tag, "/hold_ready"}, bus.s_ready, 0);
      end
      check({tag, "/busy"}, busy, (!quick && !done));
      if (quick) check({tag, "/ready_quick"}, bus.s_ready, 0);
      check({tag, "/ready_and_write"}, (bus.s_ready && bus.m_write), 0);
      if (bus.m_write) begin
        if (!first_done) first_hold++;
        if (bus.m_waitrequest) stall_seen++;
      end
      prev_stall = bus.m_write && bus.m_waitrequest;
      pa = bus.m_address;
      pd = bus.m_writedata;
      pb = bus.m_byteenable;
      if (bus.m_write && !bus.m_waitrequest) begin
        first_done = 1;
        if (widx < exp_q.size()) begin
          check({tag, "/wr_addr"}, bus.m_address, exp_q[widx].addr);
          check({tag, "/wr_data"}, bus.m_writedata, exp_q[widx].data);
          check({tag, "/wr_be"}, bus.m_byteenable, exp_q[widx].be);
        end else begin
          check({tag, "/extra_write"}, widx + 1, exp_q.size());
        end
        widx++;
      end
      if (bus.s_valid && bus.s_ready) idx++;
      if (done) begin
        done_cnt++;
        check({tag, "/error"}, error, exp_err);
        if (quick) check({tag, "/done_latency"}, cyc, 1);
        finished = 1;
      end else begin
        check({tag, "/error_without_done"}, error, 0);
      end

      @(posedge clk); #1;
      start = poke && (cyc == 3);
      if (start) begin
        base_addr = '0;
        byte_count = LEN_W'(1);
      end
      if (idx < count) begin
        bus.s_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.s_data  = src[idx];
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
      end
      case (wmode)
        1:       bus.m_waitrequest = (stall_seen < 3);
        2:       bus.m_waitrequest = ($urandom_range(0, 2) == 0);
        default: bus.m_waitrequest = 1'b0;
      endcase
    end
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_waitrequest = 1'b0;

    check({tag, "/done_seen"}, finished, 1);
    check({tag, "/done_count"}, done_cnt, 1);
    check({tag, "/num_writes"}, widx, exp_q.size());
    if (!quick) check({tag, "/bytes_taken"}, idx, count);
    if (wmode == 1) begin
      check({tag, "/stall_cycles"}, stall_seen, 3);
      check({tag, "/first_hold"}, first_hold, 4);
    end
    @(negedge clk);
    check({tag, "/done_drop"}, done, 0);
    check({tag, "/error_drop"}, error, 0);
    check({tag, "/busy_after"}, busy, 0);
    check({tag, "/write_after"}, bus.m_write, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int idx;
    int cnt;
    int base;

    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    byte_count = '0;
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    bus.m_waitrequest = 1'b0;
    #12;
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/error", error, 0);
    check("reset/s_ready", bus.s_ready, 0);
    check("reset/m_write", bus.m_write, 0);
    check("reset/m_address", bus.m_address, 0);
    check("reset/m_byteenable", bus.m_byteenable, 0);
    check("reset/m_writedata", bus.m_writedata, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 8; k++) src[k] = 8'(k + 1);
    run_xfer("two_words", 0, 8, 0, 0, 0);

    src[0] = 8'hAA; src[1] = 8'hBB; src[2] = 8'hCC; src[3] = 8'hDD; src[4] = 8'hEE;
    run_xfer("tail_one", 10, 5, 0, 0, 0);

    for (int k = 0; k < 64; k++) src[k] = 8'($urandom);
    run_xfer("stall3", 100, 6, 0, 1, 0);

    run_xfer("range_err", 24575, 5, 0, 0, 0);
    run_xfer("zero_count", 300, 0, 0, 0, 0);
    run_xfer("start_while_busy", 200, 12, 0, 0, 1);
    run_xfer("top_fit", 24574, 8, 1, 2, 0);
    run_xfer("top_over", 24574, 9, 0, 0, 0);

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 64; k++) src[k] = 8'($urandom);
      cnt  = $urandom_range(1, 40);
      base = $urandom_range(0, DEPTH - (cnt + 3) / 4);
      run_xfer("random", base, cnt, 1, 2, 0);
    end

    // Abort a transfer with reset while a write is pending on the bus.
    for (int k = 0; k < 8; k++) src[k] = 8'(8'h30 + k);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = ADDR_W'(50);
    byte_count = LEN_W'(8);
    bus.s_valid = 1'b1;
    bus.s_data = src[0];
    bus.m_waitrequest = 1'b1;
    idx = 0;
    seen = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      @(negedge clk);
      if (bus.m_write) seen = 1;
      else begin
        if (bus.s_valid && bus.s_ready) idx++;
        @(posedge clk); #1;
        bus.s_data = src[idx % 8];
      end
    end
    check("abort/write_seen", seen, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort/m_write", bus.m_write, 0);
    check("abort/busy", busy, 0);
    check("abort/s_ready", bus.s_ready, 0);
    check("abort/done", done, 0);
    check("abort/m_byteenable", bus.m_byteenable, 0);
    bus.s_valid = 1'b0;
    bus.m_waitrequest = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 64; k++) src[k] = 8'($urandom);
    run_xfer("after_abort", 50, 7, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
